// File: rtl/tone_gen.sv
// Square-wave speaker tone plus LED blink with glitch-free period updates at toggles.
// Optional TONE_GEN_NOTE_SYNC_EN adds a two-flop synchronizer on note_en.
module tone_gen #(
  parameter int LED_PRESCALE = 1000,
  parameter int CW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          note_en,
  input  logic [CW-1:0] half_period,
  input  logic [CW-1:0] led_period,
  output logic          spk,
  output logic          led,
  output logic          active,
  output logic          edge_pulse,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          spk_q, spk_d;
  logic          led_q, led_d;
  logic          edge_q, edge_d;
  logic          active_q, active_d;
  logic [CW-1:0] tone_cnt_q, tone_cnt_d;
  logic [CW-1:0] l_q, l_d;
  logic [31:0]   led_cnt_q, led_cnt_d;
  logic [31:0]   led_load;
  logic          note_s;
  logic          tone_exp;
  logic          go_idle;

`ifdef TONE_GEN_NOTE_SYNC_EN
  logic note_meta_q, note_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_meta_q <= 1'b0;
      note_sync_q <= 1'b0;
    end else begin
      note_meta_q <= note_en;
      note_sync_q <= note_meta_q;
    end
  end
  assign note_s = note_sync_q;
`else
  assign note_s = note_en;
`endif

  assign led_load = 32'(led_period) * 32'(LED_PRESCALE);

  always_comb begin
    state_d    = state_q;
    spk_d      = spk_q;
    led_d      = led_q;
    edge_d     = 1'b0;
    tone_cnt_d = tone_cnt_q;
    led_cnt_d  = led_cnt_q;
    l_d        = l_q;
    tone_exp   = (tone_cnt_q == '0);
    go_idle    = 1'b0;
    case (state_q)
      IDLE: begin
        spk_d      = 1'b0;
        led_d      = 1'b0;
        tone_cnt_d = '0;
        led_cnt_d  = '0;
        l_d        = '0;
        if (note_s && (half_period != '0)) begin
          state_d    = RUN;
          spk_d      = 1'b1;
          edge_d     = 1'b1;
          tone_cnt_d = half_period - CW'(1);
          l_d        = led_period;
          led_cnt_d  = led_load - 32'd1;
        end
      end
      RUN, DRAIN: begin
        if (!tone_exp) tone_cnt_d = tone_cnt_q - CW'(1);
        // A low-phase release ends immediately; a high phase always completes.
        if ((state_q == RUN) && !note_s && !spk_q) begin
          go_idle = 1'b1;
        end else if (tone_exp) begin
          if ((state_q == DRAIN) || !note_s || (half_period == '0)) begin
            go_idle = 1'b1;
          end else begin
            spk_d      = ~spk_q;
            edge_d     = ~spk_q;
            tone_cnt_d = half_period - CW'(1);
          end
        end else if ((state_q == RUN) && !note_s) begin
          state_d = DRAIN;
        end

        if (l_q == '0) begin
          led_d     = 1'b0;
          l_d       = led_period;
          led_cnt_d = led_load - 32'd1;
        end else if (led_cnt_q == '0) begin
          l_d       = led_period;
          led_d     = (led_period != '0) ? ~led_q : 1'b0;
          led_cnt_d = led_load - 32'd1;
        end else begin
          led_cnt_d = led_cnt_q - 32'd1;
        end

        if (go_idle) begin
          state_d    = IDLE;
          spk_d      = 1'b0;
          led_d      = 1'b0;
          tone_cnt_d = '0;
          led_cnt_d  = '0;
          l_d        = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      spk_q      <= 1'b0;
      led_q      <= 1'b0;
      edge_q     <= 1'b0;
      active_q   <= 1'b0;
      tone_cnt_q <= '0;
      led_cnt_q  <= '0;
      l_q        <= '0;
    end else begin
      state_q    <= state_d;
      spk_q      <= spk_d;
      led_q      <= led_d;
      edge_q     <= edge_d;
      active_q   <= active_d;
      tone_cnt_q <= tone_cnt_d;
      led_cnt_q  <= led_cnt_d;
      l_q        <= l_d;
    end
  end

  assign spk        = spk_q;
  assign led        = led_q;
  assign edge_pulse = edge_q;
  assign active     = active_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/tone_gen.md
# tone_gen

Square-wave tone and LED blink generator. It consumes the octave-scaled half-period count and LED update value produced upstream and drives the speaker pin and note-indicator LED. It sits between the octave scaling stage and the board I/O. All period changes are applied only on a speaker toggle so the output never glitches, and a released note always finishes low.

## Interface
Parameters:
- `LED_PRESCALE`, 1000: clocks per LED period unit.
- `CW`, 20: width of period inputs.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `note_en`  in  1: note key held.
- `half_period`  in  CW: speaker half-period in clocks (octave-scaled counter value).
- `led_period`  in  CW: LED half-period in units of `LED_PRESCALE` clocks.
- `spk`  out  1: speaker square wave.
- `led`  out  1: blink output.
- `active`  out  1: high whenever the state is not IDLE.
- `edge_pulse`  out  1: one-cycle pulse in the same cycle `spk` rises.

## Operation
- States: IDLE, RUN, DRAIN.
- **IDLE**
  - `spk` = 0, `led` = 0, counters cleared.
  - If `note_en` = 1 and `half_period` != 0: latch P = `half_period` and L = `led_period`, set `spk` = 1, pulse `edge_pulse`, load the tone counter, and go to RUN.
  - If `note_en` = 1 and `half_period` = 0: remain in IDLE.
- **RUN**
  - The tone counter runs for P clocks per half-period.
  - On expiry, re-sample `half_period` as the new P and toggle `spk`. A rising toggle pulses `edge_pulse`.
  - If the re-sampled P = 0: force `spk` = 0 and go to IDLE.
  - Changes to `half_period` mid-half-period have no effect until the next toggle.
- **note_en deasserted in RUN**
  - If `spk` = 0: go to IDLE next cycle.
  - If `spk` = 1: go to DRAIN.
- **DRAIN**
  - Finish the current high half-period with the current P.
  - On expiry, set `spk` = 0 and go to IDLE. No rising edge occurs.
  - `note_en` is ignored until IDLE is reached.
- **LED**
  - While `active`: the LED counter counts L × `LED_PRESCALE` clocks, then toggles `led` and re-samples L.
  - L = 0 holds `led` at 0.
  - LED counter width is 32 bits. The product is computed with no truncation for CW = 20 and `LED_PRESCALE` ≤ 4095.
- `led` is cleared on entry to IDLE.
- All arithmetic is unsigned.

## Timing
- All outputs are registered.
- Reset values: `spk` = 0, `led` = 0, `active` = 0, `edge_pulse` = 0, state IDLE.
- Reset is asynchronous and may assert mid-note. Outputs go to reset values immediately, and the block restarts from IDLE.
- Start latency: `note_en` sampled high at edge N gives `spk` = 1, `active` = 1 and `edge_pulse` = 1 after edge N.
- Each half-period is exactly P clocks, so the full tone period is 2P clocks.
- P = 1 toggles `spk` every clock.
- After release with `spk` = 0: `active` falls one clock later.
- After release with `spk` = 1: `active` falls P − k clocks later, where k clocks of the half-period had already elapsed when `note_en` was sampled low.
- First LED toggle occurs L × `LED_PRESCALE` clocks after RUN entry.
- `note_en` is used as-is (not synchronized) without the configuration macro.

## Configuration
- `TONE_GEN_NOTE_SYNC_EN`
  - Defined: `note_en` passes through a two-flop synchronizer, reset to 0. Start and release latency each grow by 2 clocks.
  - Undefined: `note_en` is sampled directly. The upstream switch path must already be synchronous.

## Test plan
- **Basic tone:** reset, `half_period` = 4, `led_period` = 0, `note_en` = 1 for 40 clocks.
  - `spk` alternates high 4 / low 4.
  - `edge_pulse` fires every 8 clocks.
  - `led` stays 0.
- **Period change mid-half-period:** while running with P = 4, switch `half_period` to 2 at clock 2 of a high phase.
  - The current high phase still lasts 4 clocks.
  - Subsequent phases last 2 clocks.
- **Release while high:** P = 6, drop `note_en` 2 clocks into a high phase.
  - `spk` stays high 4 more clocks, then goes to 0.
  - `active` falls with it.
  - No further `edge_pulse`.
- **Zero period:** in RUN with P = 3, set `half_period` = 0.
  - At the next toggle `spk` = 0 and state is IDLE.
  - With `note_en` still 1 and `half_period` = 0, the block does not restart.
- **LED blink:** `LED_PRESCALE` = 10, `led_period` = 3, P = 5.
  - `led` toggles every 30 clocks while active.
  - `led` returns to 0 on release.
- **Async reset mid-note:** pulse `rst_n` low during a high phase.
  - All outputs are 0 immediately.
  - After release, with `note_en` still high, the tone restarts with `spk` = 1 one clock later (3 clocks with `TONE_GEN_NOTE_SYNC_EN`).
